// File: rtl/multi_op_reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_op_reg_file_if
// Description : Bus bundle for multi_op_reg_file: load data, per-register
//               operation select and enables, two read selects, two read
//               data ports and the wrap status flag.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface multi_op_reg_file_if #(
    parameter int WIDTH = 8,
    parameter int NR    = 4,
    parameter int NT    = 4
);
    // Read select width covers every T and R register; never narrower than 1
    localparam int SEL_W = ($clog2(NT + NR) < 1) ? 1 : $clog2(NT + NR);

    logic [WIDTH-1:0] I;
    logic [2:0]       FunSel;
    logic [NR-1:0]    RSel;
    logic [NT-1:0]    TSel;
    logic [SEL_W-1:0] O1Sel;
    logic [SEL_W-1:0] O2Sel;
    logic [WIDTH-1:0] O1;
    logic [WIDTH-1:0] O2;
    logic             wrap;

    // Datapath side: drives operation and selects, observes read data
    modport master (
        output I, FunSel, RSel, TSel, O1Sel, O2Sel,
        input  O1, O2, wrap
    );

    // Register file side
    modport slave (
        input  I, FunSel, RSel, TSel, O1Sel, O2Sel,
        output O1, O2, wrap
    );
endinterface
`default_nettype wire

// File: rtl/multi_op_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : multi_op_reg_file
// Description : NT temporary + NR general registers, WIDTH bits each. One
//               operation (FunSel) per clock is applied independently to
//               every enabled register; two combinational read ports; a
//               registered wrap flag reports inc/dec wrap-around.
//               Register index map: 0..NT-1 = T1..T(NT), NT.. = R1..R(NR).
//               WIDTH must be at least 2.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module multi_op_reg_file #(
    parameter int WIDTH = 8,
    parameter int NR    = 4,
    parameter int NT    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    multi_op_reg_file_if.slave  bus
);
    localparam int NREG  = NR + NT;
    localparam int SEL_W = ($clog2(NT + NR) < 1) ? 1 : $clog2(NT + NR);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_DEC   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_SHR   = 3'b110;
    localparam logic [2:0] OP_ROL   = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             wrap_q;
    logic             wrap_d;
    logic [NREG-1:0]  en;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;

    // Enable bit k lines up with register index k (T first, then R)
    assign en = {bus.RSel, bus.TSel};

    // Next-state for every register plus the wrap detection across enabled ones
    always_comb begin
        wrap_d = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (en[i]) begin
                case (bus.FunSel)
                    OP_HOLD:  regs_d[i] = regs_q[i];
                    OP_LOAD:  regs_d[i] = bus.I;
                    OP_CLEAR: regs_d[i] = '0;
                    OP_INC: begin
                        regs_d[i] = regs_q[i] + ONE;
                        if (&regs_q[i]) wrap_d = 1'b1;
                    end
                    OP_DEC: begin
                        regs_d[i] = regs_q[i] - ONE;
                        if (~|regs_q[i]) wrap_d = 1'b1;
                    end
                    OP_SHL:   regs_d[i] = {regs_q[i][WIDTH-2:0], 1'b0};
                    OP_SHR:   regs_d[i] = {1'b0, regs_q[i][WIDTH-1:1]};
                    OP_ROL:   regs_d[i] = {regs_q[i][WIDTH-2:0], regs_q[i][WIDTH-1]};
                    default:  regs_d[i] = regs_q[i];
                endcase
            end
        end
    end

    // State registers; asynchronous reset clears everything including wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wrap_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wrap_q <= wrap_d;
        end
    end

    // Read ports: decoded select, out-of-range indices fall through to zero
    always_comb begin
        o1 = '0;
        o2 = '0;
        for (int i = 0; i < NREG; i++) begin
            if (bus.O1Sel == SEL_W'(i)) o1 = regs_q[i];
            if (bus.O2Sel == SEL_W'(i)) o2 = regs_q[i];
        end
    end

    assign bus.O1   = o1;
    assign bus.O2   = o2;
    assign bus.wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_op_reg_file.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_multi_op_reg_file
// Description : Self-checking bench for multi_op_reg_file. Three instances
//               (8b 4R/4T, 8b 3R/3T, 16b 2R/2T) against an arithmetic
//               reference model; directed scenarios followed by random ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_op_reg_file;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    // Reference model: [instance][index], index 0..NT-1 = T, NT.. = R
    logic [15:0] mdl [3][8];
    logic        mwr [3];

    multi_op_reg_file_if #(.WIDTH(8),  .NR(4), .NT(4)) ifa ();
    multi_op_reg_file_if #(.WIDTH(8),  .NR(3), .NT(3)) ifb ();
    multi_op_reg_file_if #(.WIDTH(16), .NR(2), .NT(2)) ifc ();

    multi_op_reg_file #(.WIDTH(8),  .NR(4), .NT(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    multi_op_reg_file #(.WIDTH(8),  .NR(3), .NT(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    multi_op_reg_file #(.WIDTH(16), .NR(2), .NT(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Applies one edge's worth of the operation rules with plain arithmetic
    task automatic model_step(input int k, input int w, input int nr, input int nt,
                              input logic [2:0] f, input logic [15:0] d,
                              input logic [15:0] rs, input logic [15:0] ts);
        int unsigned m;
        m = 32'd1 << w;
        mwr[k] = 1'b0;
        for (int i = 0; i < nr + nt; i++) begin
            bit en;
            int unsigned x;
            int unsigned y;
            en = (i < nt) ? ts[i] : rs[i - nt];
            x  = int'(mdl[k][i]);
            y  = x;
            if (en) begin
                case (f)
                    3'd1: y = int'(d) % m;
                    3'd2: y = 0;
                    3'd3: y = (x + 1) % m;
                    3'd4: y = (x + m - 1) % m;
                    3'd5: y = (x * 2) % m;
                    3'd6: y = x / 2;
                    3'd7: y = (x * 2 + x / (m / 2)) % m;
                    default: y = x;
                endcase
                if ((f == 3'd3 && x == m - 1) || (f == 3'd4 && x == 0)) mwr[k] = 1'b1;
                mdl[k][i] = 16'(y);
            end
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) mdl[k][i] = '0;
            mwr[k] = 1'b0;
        end
    endtask

    task automatic step_a(input logic [15:0] d, input logic [2:0] f,
                          input logic [15:0] rs, input logic [15:0] ts);
        @(negedge clk);
        ifa.I = d[7:0]; ifa.FunSel = f; ifa.RSel = rs[3:0]; ifa.TSel = ts[3:0];
        ifa.O1Sel = 3'($urandom_range(0, 7));
        #1 check("a_pre_edge", 16'(ifa.O1), mdl[0][ifa.O1Sel]);
        @(posedge clk);
        model_step(0, 8, 4, 4, f, d, rs, ts);
        #1 check("a_wrap", 16'(ifa.wrap), 16'(mwr[0]));
        for (int i = 0; i < 8; i++) begin
            ifa.O1Sel = 3'(i); ifa.O2Sel = 3'(7 - i);
            #1;
            check($sformatf("a_o1[%0d]", i), 16'(ifa.O1), mdl[0][i]);
            check($sformatf("a_o2[%0d]", 7 - i), 16'(ifa.O2), mdl[0][7 - i]);
        end
        ifa.FunSel = 3'b000;
    endtask

    task automatic step_b(input logic [15:0] d, input logic [2:0] f,
                          input logic [15:0] rs, input logic [15:0] ts);
        @(negedge clk);
        ifb.I = d[7:0]; ifb.FunSel = f; ifb.RSel = rs[2:0]; ifb.TSel = ts[2:0];
        @(posedge clk);
        model_step(1, 8, 3, 3, f, d, rs, ts);
        #1 check("b_wrap", 16'(ifb.wrap), 16'(mwr[1]));
        for (int i = 0; i < 8; i++) begin
            ifb.O1Sel = 3'(i); ifb.O2Sel = 3'(7 - i);
            #1;
            check($sformatf("b_o1[%0d]", i), 16'(ifb.O1), (i < 6) ? mdl[1][i] : 16'h0);
            check($sformatf("b_o2[%0d]", 7 - i), 16'(ifb.O2), (7 - i < 6) ? mdl[1][7 - i] : 16'h0);
        end
        ifb.FunSel = 3'b000;
    endtask

    task automatic step_c(input logic [15:0] d, input logic [2:0] f,
                          input logic [15:0] rs, input logic [15:0] ts);
        @(negedge clk);
        ifc.I = d; ifc.FunSel = f; ifc.RSel = rs[1:0]; ifc.TSel = ts[1:0];
        @(posedge clk);
        model_step(2, 16, 2, 2, f, d, rs, ts);
        #1 check("c_wrap", 16'(ifc.wrap), 16'(mwr[2]));
        for (int i = 0; i < 4; i++) begin
            ifc.O1Sel = 2'(i); ifc.O2Sel = 2'(3 - i);
            #1;
            check($sformatf("c_o1[%0d]", i), ifc.O1, mdl[2][i]);
            check($sformatf("c_o2[%0d]", 3 - i), ifc.O2, mdl[2][3 - i]);
        end
        ifc.FunSel = 3'b000;
    endtask

    function automatic logic [15:0] rnd_data();
        int unsigned r;
        r = $urandom_range(0, 3);
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'hFFFF;
        return 16'($urandom);
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_model();
        rst_n = 1'b0;
        ifa.I = '0; ifa.FunSel = '0; ifa.RSel = '0; ifa.TSel = '0; ifa.O1Sel = '0; ifa.O2Sel = '0;
        ifb.I = '0; ifb.FunSel = '0; ifb.RSel = '0; ifb.TSel = '0; ifb.O1Sel = '0; ifb.O2Sel = '0;
        ifc.I = '0; ifc.FunSel = '0; ifc.RSel = '0; ifc.TSel = '0; ifc.O1Sel = '0; ifc.O2Sel = '0;
        #5;
        check("rst_a_o1", 16'(ifa.O1), 16'h0);
        check("rst_a_wrap", 16'(ifa.wrap), 16'h0);
        check("rst_c_o2", ifc.O2, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a cycle, with wrap set
        step_a(16'h00A5, 3'b001, 16'b0001, 16'b0000);
        step_a(16'h00FF, 3'b001, 16'b0000, 16'b0010);
        step_a(16'h0000, 3'b011, 16'b0000, 16'b0010);
        #3;
        ifa.O1Sel = 3'd4;
        #1 check("t1_pre_rst_R1", 16'(ifa.O1), 16'h00A5);
        check("t1_pre_rst_wrap", 16'(ifa.wrap), 16'h1);
        rst_n = 1'b0;
        #1 check("t1_rst_R1", 16'(ifa.O1), 16'h0000);
        check("t1_rst_wrap", 16'(ifa.wrap), 16'h0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;

        // Out-of-range select on the 3R/3T instance
        step_b(16'h005A, 3'b001, 16'b111, 16'b111);
        ifb.O1Sel = 3'd6;
        #1 check("t1_b_sel6", 16'(ifb.O1), 16'h00);
        ifb.O1Sel = 3'd5;
        #1 check("t1_b_sel5", 16'(ifb.O1), 16'h5A);

        // Load and read mapping
        step_a(16'h0018, 3'b001, 16'b0100, 16'b0001);
        ifa.O1Sel = 3'd6; ifa.O2Sel = 3'd0;
        #1 check("t2_R3", 16'(ifa.O1), 16'h18);
        check("t2_T1", 16'(ifa.O2), 16'h18);

        // Increment wrap
        step_a(16'h00FF, 3'b001, 16'b0001, 16'b0000);
        step_a(16'h0010, 3'b001, 16'b0000, 16'b0010);
        step_a(16'h0000, 3'b011, 16'b0001, 16'b0010);
        ifa.O1Sel = 3'd4; ifa.O2Sel = 3'd1;
        #1 check("t3_R1", 16'(ifa.O1), 16'h00);
        check("t3_T2", 16'(ifa.O2), 16'h11);
        check("t3_wrap", 16'(ifa.wrap), 16'h1);
        step_a(16'h0000, 3'b000, 16'b1111, 16'b1111);
        check("t3_wrap_hold", 16'(ifa.wrap), 16'h0);

        // Decrement wrap with all enables
        step_a(16'h0000, 3'b010, 16'b1111, 16'b1111);
        step_a(16'h0000, 3'b100, 16'b1111, 16'b1111);
        ifa.O1Sel = 3'd7; ifa.O2Sel = 3'd0;
        #1 check("t4_R4", 16'(ifa.O1), 16'hFF);
        check("t4_T1", 16'(ifa.O2), 16'hFF);
        check("t4_wrap", 16'(ifa.wrap), 16'h1);
        step_a(16'h0000, 3'b100, 16'b1111, 16'b1111);
        ifa.O1Sel = 3'd5;
        #1 check("t4_R2_fe", 16'(ifa.O1), 16'hFE);
        check("t4_wrap2", 16'(ifa.wrap), 16'h0);

        // Shift and rotate on T1
        step_a(16'h0096, 3'b001, 16'b0000, 16'b0001);
        step_a(16'h0000, 3'b101, 16'b0000, 16'b0001);
        ifa.O1Sel = 3'd0;
        #1 check("t5_shl", 16'(ifa.O1), 16'h2C);
        step_a(16'h0000, 3'b110, 16'b0000, 16'b0001);
        ifa.O1Sel = 3'd0;
        #1 check("t5_shr", 16'(ifa.O1), 16'h16);
        step_a(16'h0000, 3'b111, 16'b0000, 16'b0001);
        ifa.O1Sel = 3'd0;
        #1 check("t5_rol", 16'(ifa.O1), 16'h2C);

        // 16-bit instance rotate
        step_c(16'h8001, 3'b001, 16'b10, 16'b00);
        step_c(16'h0000, 3'b111, 16'b10, 16'b00);
        ifc.O1Sel = 2'd3;
        #1 check("t6_R2_rol", ifc.O1, 16'h0003);

        // Random operations against the reference model
        for (int n = 0; n < 200; n++)
            step_a(rnd_data(), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
        for (int n = 0; n < 40; n++)
            step_b(rnd_data(), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
        for (int n = 0; n < 40; n++)
            step_c(rnd_data(), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always ends on its own
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/multi_op_reg_file.md
# multi_op_reg_file

- Parametrised successor to the fixed 8-bit, 4+4 register file (part2b).
- Holds NR general registers (R) and NT temporary registers (T), each WIDTH bits wide, with two independent combinational read ports.
- One synchronous per-register operation is applied per clock to every enabled register, with an extended operation set and a registered wrap status flag.
- Sits between the ALU result bus and the ALU operand inputs in the datapath.

## Interface

Parameters:

- WIDTH, default 8: register and data width.
- NR, default 4: number of general registers R1..R(NR).
- NT, default 4: number of temporary registers T1..T(NT).
- SEL_W: derived localparam, not overridable. Equals clog2(NT+NR), with a minimum of 1.

Ports:

- clk  in  1: rising-edge clock; the block's only clock.
- rst_n  in  1: asynchronous, active-low reset.
- I  in  WIDTH: load data.
- FunSel  in  3: operation applied to enabled registers.
- RSel  in  NR: RSel[k] enables R(k+1).
- TSel  in  NT: TSel[k] enables T(k+1).
- O1Sel  in  SEL_W: read select for port 1.
- O2Sel  in  SEL_W: read select for port 2.
- O1  out  WIDTH: read port 1, combinational.
- O2  out  WIDTH: read port 2, combinational.
- wrap  out  1: registered flag; 1 when an inc/dec wrapped on the last edge.

## Operation

- **Reset:** rst_n low clears all registers and wrap to 0 immediately, independent of clk. This includes reset mid-operation. Reset has priority over any FunSel.
- **Read mapping:** Osel 0..NT-1 selects T1..T(NT); NT..NT+NR-1 selects R1..R(NR). Any out-of-range select drives all zeros.
- **Read ports:**
  - Both ports are purely combinational from register state.
  - Both ports may select the same register.
  - A read never affects state.
- **FunSel encoding** (applied at the rising edge, to each enabled register):
  - 000 hold
  - 001 load I
  - 010 clear to 0
  - 011 increment, mod 2^WIDTH
  - 100 decrement, mod 2^WIDTH
  - 101 shift left logical, LSB filled with 0
  - 110 shift right logical, MSB filled with 0
  - 111 rotate left by 1
- **Disabled registers** hold regardless of FunSel.
- **Multiple enables:** RSel and TSel may enable any number of registers at once. Each enabled register applies the operation to its own value independently; there is no interaction between registers.
- **wrap flag:**
  - Set at the edge if FunSel=011 and any enabled register was all-ones, or FunSel=100 and any enabled register was zero.
  - Otherwise cleared at every edge, including hold.
  - No enables means wrap=0.
- **Arithmetic:** all operations are unsigned WIDTH-bit. Results truncate to WIDTH bits.

## Timing

- Write latency is 1 cycle: a register reflects the operation after the rising edge where enable and FunSel were sampled.
- Read latency is 0 cycles. O1/O2 follow select and register changes combinationally.
- A read of a register being written in the same cycle returns the pre-edge value.
- wrap is valid from the same edge as the register update and persists exactly one cycle unless re-triggered.
- Inputs I, FunSel, RSel, TSel and the selects must be stable around the rising edge. There is no handshake; every cycle is an accepted operation.
- Reset release is synchronous-safe: the first edge after rst_n rises applies the operation present then.
- Reset values: every register 0, wrap 0, so O1=O2=0.

## Test plan

1. **Reset and out-of-range select.**
   - Stimulus: assert rst_n=0 mid-cycle after loading R1=8'hA5. Then set O1Sel to an out-of-range index (set NR=3, NT=3 in a second instance; select 6).
   - Required: O1=8'h00 immediately on reset, without waiting for a clock, and wrap=0. With NR=3/NT=3, Osel=6 gives 8'h00.
2. **Load and read mapping.**
   - Stimulus: I=8'h18, FunSel=001, RSel=4'b0100, TSel=4'b0001, one edge. Then O1Sel=6, O2Sel=0.
   - Required: O1=8'h18 (R3) and O2=8'h18 (T1). All other registers read 8'h00.
3. **Increment wrap.**
   - Stimulus: load R1=8'hFF and T2=8'h10. Then apply FunSel=011 with RSel=0001, TSel=0010 for one edge.
   - Required: R1=8'h00, T2=8'h11, wrap=1 for one cycle. A following hold cycle gives wrap=0.
4. **Decrement wrap and simultaneous enables.**
   - Stimulus: clear all, then FunSel=100 with all enables for one edge.
   - Required: every register reads 8'hFF and wrap=1. A second decrement gives 8'hFE and wrap=0.
5. **Shift and rotate.**
   - Stimulus: load T1=8'b1001_0110. Apply 101, then 110, then 111, one edge each.
   - Required, in order: 8'b0010_1100, then 8'b0001_0110, then 8'b0010_1100.
6. **Width generality.**
   - Stimulus: a WIDTH=16, NR=2, NT=2 instance. Load R2=16'h8001, then rotate left.
   - Required: O1 (Osel=3) reads 16'h0003.
